// File: rtl/x25519_carry_unit.sv
// x25519_carry_unit
//   Carry-propagation and normalisation engine for radix-2^51 GF(2^255-19)
//   field elements. Limbs are loaded serially, each limb is split into a
//   masked low part and a carry that is added into the next limb, the carry
//   out of the top limb is folded back into limb 0 multiplied by FOLD, and
//   the normalised limbs are streamed out serially.
//
// Ports
//   g_clk      in   clock, rising edge
//   g_resetn   in   asynchronous active-low reset
//   in_valid   in   in_limb holds a valid limb
//   in_ready   out  block accepts a limb this cycle (LOAD only)
//   in_limb    in   64-bit input limb, least significant limb first
//   out_valid  out  out_limb holds a valid result limb (DRAIN only)
//   out_ready  in   consumer accepts out_limb this cycle
//   out_limb   out  normalised 64-bit limb
//   out_idx    out  index of the current out_limb
//   busy       out  high in every state except LOAD
//
// Results are only partially reduced: limbs 0 and 2..LIMBS-1 are below
// 2^RADIX, limb 1 may reach 2^RADIX. Modular correctness holds when every
// input limb is below 2^63.

module x25519_carry_unit #(
  parameter int LIMBS = 5,
  parameter int RADIX = 51,
  parameter int FOLD  = 19
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_limb,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_limb,
  output logic [2:0]  out_idx,
  output logic        busy
);

  localparam int          TOPC_W = 64 - RADIX;
  localparam logic [63:0] MASK   = (64'd1 << RADIX) - 64'd1;
  localparam logic [2:0]  LAST   = 3'(LIMBS - 1);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_PROP  = 2'd1,
    ST_FOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_next_s;
  logic [2:0]          cnt_r;
  logic [2:0]          cnt_next_s;
  logic [63:0]         limb_r      [LIMBS];
  logic [63:0]         limb_next_s [LIMBS];
  logic [TOPC_W-1:0]   topc_r;
  logic [TOPC_W-1:0]   topc_next_s;
  logic [63:0]         carry_s;
  logic [63:0]         fold_sum_s;

  // Next-state, limb datapath and counter logic for the four-phase engine.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    limb_next_s  = limb_r;
    topc_next_s  = topc_r;
    carry_s      = limb_r[cnt_r] >> RADIX;
    // topc is at most 2^TOPC_W-1, so the product cannot wrap 64 bits.
    fold_sum_s   = limb_r[0] + (64'(FOLD) * 64'(topc_r));

    case (state_r)
      ST_LOAD: begin
        // in_ready is high throughout LOAD, so in_valid alone means a beat.
        if (in_valid) begin
          limb_next_s[cnt_r] = in_limb;
          if (cnt_r == LAST) begin
            state_next_s = ST_PROP;
            cnt_next_s   = 3'd0;
          end else begin
            cnt_next_s = cnt_r + 3'd1;
          end
        end else begin
          cnt_next_s = cnt_r;
        end
      end

      ST_PROP: begin
        limb_next_s[cnt_r] = limb_r[cnt_r] & MASK;
        if (cnt_r == LAST) begin
          // Carry out of the top limb is held for the fold step.
          topc_next_s  = carry_s[TOPC_W-1:0];
          state_next_s = ST_FOLD;
          cnt_next_s   = 3'd0;
        end else begin
          limb_next_s[cnt_r + 3'd1] = limb_r[cnt_r + 3'd1] + carry_s;
          cnt_next_s                = cnt_r + 3'd1;
        end
      end

      ST_FOLD: begin
        // 2^(RADIX*LIMBS) == FOLD mod p, so the top carry re-enters limb 0.
        limb_next_s[0] = fold_sum_s & MASK;
        limb_next_s[1] = limb_r[1] + (fold_sum_s >> RADIX);
        state_next_s   = ST_DRAIN;
        cnt_next_s     = 3'd0;
      end

      ST_DRAIN: begin
        // out_valid is high throughout DRAIN, so out_ready alone means a beat.
        if (out_ready) begin
          if (cnt_r == LAST) begin
            state_next_s = ST_LOAD;
            cnt_next_s   = 3'd0;
          end else begin
            cnt_next_s = cnt_r + 3'd1;
          end
        end else begin
          cnt_next_s = cnt_r;
        end
      end

      default: begin
        state_next_s = ST_LOAD;
        cnt_next_s   = 3'd0;
      end
    endcase
  end

  // State, counter, limb and top-carry registers.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_r <= ST_LOAD;
      cnt_r   <= 3'd0;
      topc_r  <= '0;
      for (int i = 0; i < LIMBS; i++) begin
        limb_r[i] <= 64'd0;
      end
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      topc_r  <= topc_next_s;
      limb_r  <= limb_next_s;
    end
  end

  // Registered stream outputs, decoded from the next state so they line up
  // with the state register.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_limb  <= 64'd0;
      out_idx   <= 3'd0;
      busy      <= 1'b0;
    end else begin
      in_ready  <= (state_next_s == ST_LOAD);
      out_valid <= (state_next_s == ST_DRAIN);
      out_limb  <= (state_next_s == ST_DRAIN) ? limb_next_s[cnt_next_s] : 64'd0;
      out_idx   <= (state_next_s == ST_DRAIN) ? cnt_next_s : 3'd0;
      busy      <= (state_next_s != ST_LOAD);
    end
  end

endmodule

// File: tb/tb_x25519_carry_unit.sv
// Scoreboard bench for x25519_carry_unit: expected limbs are queued when an
// element is issued and a monitor pops and compares every accepted output.

module tb_x25519_carry_unit;

  localparam logic [63:0] MASK = (64'd1 << 51) - 64'd1;
  localparam logic [63:0] P51  = 64'd1 << 51;

  typedef logic [63:0] elem_t [5];
  typedef struct packed {
    logic [2:0]  idx;
    logic [63:0] limb;
  } beat_t;

  logic        g_clk    = 1'b0;
  logic        g_resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_limb  = 64'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_limb;
  logic [2:0]  out_idx;
  logic        busy;

  beat_t exp_q[$];
  int    checks     = 0;
  int    errors     = 0;
  int    cyc        = 0;
  int    stall_from = -100;
  bit    rand_ready = 1'b0;

  x25519_carry_unit dut (
    .g_clk     (g_clk),
    .g_resetn  (g_resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_limb   (in_limb),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_limb  (out_limb),
    .out_idx   (out_idx),
    .busy      (busy)
  );

  always #5 g_clk = ~g_clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  // Reference: split each limb at bit 51, add carries upward, fold 19*top carry.
  task automatic model(input elem_t v, output elem_t r);
    logic [63:0] c;
    logic [63:0] t;
    r = v;
    for (int i = 0; i < 5; i++) begin
      c    = r[i] >> 51;
      r[i] = r[i] & MASK;
      if (i < 4) begin
        r[i+1] = r[i+1] + c;
      end else begin
        t    = r[0] + 64'd19 * c;
        r[0] = t & MASK;
        r[1] = r[1] + (t >> 51);
      end
    end
  endtask

  task automatic push_exp(input elem_t e);
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back('{idx: 3'(k), limb: e[k]});
    end
  endtask

  task automatic send_elem(input elem_t v, input bit gaps);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_limb  = v[k];
      @(posedge g_clk); #1;
      if (gaps && k < 4) begin
        in_valid = 1'b0;
        in_limb  = {$urandom, $urandom};
        @(posedge g_clk); #1;
        if (k == 3) begin
          chk("toggle_load_busy", 64'(busy), 64'd0);
          chk("toggle_load_in_ready", 64'(in_ready), 64'd1);
        end
      end
    end
    in_valid = 1'b0;
    in_limb  = 64'd0;
    if (gaps) begin
      chk("toggle_prop_busy", 64'(busy), 64'd1);
      chk("toggle_prop_in_ready", 64'(in_ready), 64'd0);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge g_clk); #1;
      n++;
    end
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
    chk("idle_in_ready", 64'(in_ready), 64'd1);
    chk("idle_out_valid", 64'(out_valid), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_out_limb"}, out_limb, 64'd0);
    chk({tag, "_out_idx"}, 64'(out_idx), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic run_main();
    elem_t a, m, b, e, v, r;
    int    lat;
    int    n;

    repeat (2) @(negedge g_clk);
    chk_reset_outputs("reset");
    g_resetn = 1'b1;
    @(posedge g_clk); #1;

    // All limbs 2^51: every carry is 1, top carry folds in as 19.
    a = '{P51, P51, P51, P51, P51};
    e = '{64'd19, 64'd1, 64'd1, 64'd1, 64'd1};
    push_exp(e);
    send_elem(a, 1'b0);
    chk("busy_after_load", 64'(busy), 64'd1);
    // lat counts clock edges from the edge that took the 5th beat.
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(posedge g_clk); #1;
      lat++;
    end
    chk("first_out_latency", 64'(lat), 64'd7);
    wait_drain();

    // All limbs 2^51-1: already normalised, passes through unchanged.
    m = '{MASK, MASK, MASK, MASK, MASK};
    push_exp(m);
    send_elem(m, 1'b0);
    wait_drain();

    // Only the top limb set to all ones: topc = 8191, 8191*19 = 155629.
    b = '{64'd0, 64'd0, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF};
    e = '{64'd155629, 64'd0, 64'd0, 64'd0, MASK};
    push_exp(e);
    send_elem(b, 1'b0);
    wait_drain();

    // Back-pressure on beat 2 for three cycles.
    e = '{64'd19, 64'd1, 64'd1, 64'd1, 64'd1};
    push_exp(e);
    send_elem(a, 1'b0);
    n = 0;
    while (!(out_valid && out_idx == 3'd1) && n < 50) begin
      @(negedge g_clk);
      n++;
    end
    chk("stall_reach_beat1", 64'(n < 50), 64'd1);
    stall_from = cyc + 1;
    for (int s = 0; s < 3; s++) begin
      @(negedge g_clk);
      chk("stall_out_ready_low", 64'(out_ready), 64'd0);
      chk("stall_out_valid", 64'(out_valid), 64'd1);
      chk("stall_out_idx", 64'(out_idx), 64'd2);
      chk("stall_out_limb", out_limb, 64'd1);
    end
    wait_drain();

    // Reset while PROP is working on limb 2; the element is discarded.
    send_elem(a, 1'b0);
    @(posedge g_clk); #1;
    @(posedge g_clk); #1;
    chk("prop_busy_before_abort", 64'(busy), 64'd1);
    g_resetn = 1'b0;
    #1;
    chk_reset_outputs("abort");
    @(negedge g_clk);
    g_resetn = 1'b1;
    @(posedge g_clk); #1;
    b = '{64'd1, 64'd2, 64'd3, 64'd4, 64'd5};
    push_exp(b);
    send_elem(b, 1'b0);
    wait_drain();

    // in_valid toggling during LOAD.
    for (int k = 0; k < 5; k++) v[k] = {1'b0, $urandom, 31'($urandom)};
    model(v, r);
    push_exp(r);
    send_elem(v, 1'b1);
    wait_drain();

    // Random elements with random consumer back-pressure.
    rand_ready = 1'b1;
    for (int j = 0; j < 25; j++) begin
      for (int k = 0; k < 5; k++) begin
        v[k] = {$urandom, $urandom};
        if (j % 4 != 3) v[k][63] = 1'b0;
      end
      model(v, r);
      push_exp(r);
      send_elem(v, 1'b0);
      wait_drain();
    end
    rand_ready = 1'b0;
  endtask

  initial begin
    fork
      run_main();
      // Monitor: compare every accepted output beat against the scoreboard.
      begin
        beat_t eb;
        forever begin
          @(negedge g_clk);
          if (g_resetn && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_beat actual idx=%0d limb=0x%0h required=no beat", out_idx, out_limb);
            end else begin
              eb = exp_q.pop_front();
              chk("out_idx", 64'(out_idx), 64'(eb.idx));
              chk("out_limb", out_limb, eb.limb);
            end
          end
        end
      end
      // Consumer: out_ready driven just after each rising edge.
      begin
        forever begin
          @(posedge g_clk); #1;
          cyc++;
          if (cyc >= stall_from && cyc < stall_from + 3) out_ready = 1'b0;
          else if (rand_ready) out_ready = 1'($urandom_range(0, 1));
          else out_ready = 1'b1;
        end
      end
    join_any
    disable fork;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
